sram_pattern_engine: RTL and testbench
======================================

Name: sram_pattern_engine

Overview:
- Parametrised SRAM pattern generator, checker and player. Sits between top-level control and the sram_arbiter request port.
- On start it fills the whole address space with a selectable pattern (ramp, constant, LFSR). It then reads everything back and counts mismatches.
- Finally it streams continuous wrap-around read samples at a programmable rate, e.g. to drive a pwm duty input.

Parameters:
AW, 19, address width; depth is 2**AW words
DW, 8, data width, 1..16
DIV_W, 8, width of rate divider
SEED, 16'hACE1, constant-pattern value (low DW bits) and LFSR seed; must be nonzero

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  pulse; begins fill when idle
stop  in  1  level; return to IDLE at next safe point
mode  in  2  0 ramp, 1 constant, 2 LFSR, 3 treated as ramp; sampled at start
rate  in  DIV_W  idle cycles between playback requests
active  out  1  high in any state except IDLE
fill_done  out  1  sticky; set when fill completes
verify_done  out  1  sticky; set when verify completes
err_cnt  out  16  verify mismatch count, saturating
sample  out  DW  last playback read data
sample_valid  out  1  one-cycle strobe with new sample
mem_en  out  1  request valid
mem_we  out  1  1 write, 0 read
mem_addr  out  AW  request address
mem_wdata  out  DW  write data
mem_busy  in  1  arbiter cannot accept this cycle
mem_rdata  in  DW  read data
mem_valid  in  1  one-cycle strobe: mem_rdata valid for last accepted read

Behaviour:
- Reset: state IDLE; all outputs 0; address counter 0; LFSR = SEED; pace counter 0.
- Request transfer occurs on a cycle with mem_en=1 and mem_busy=0.
  - While mem_en=1 and mem_busy=1, mem_we/mem_addr/mem_wdata are held stable.
  - mem_en drops, or advances to the next request, on the cycle after acceptance.
- At most one read is outstanding; no new request is issued until mem_valid returns.
- Pattern generation:
  - ramp: data = addr[AW-1 -: DW] if AW>=DW, else addr zero-extended.
  - constant: data = SEED[DW-1:0].
  - LFSR: 16-bit Fibonacci, taps 16,14,13,11. Data = low DW bits. Advances once per accepted write (fill) or per compared word (verify). Re-seeded to SEED on entering FILL and VERIFY.
- States:
  - IDLE: on start=1, latch mode; clear err_cnt, fill_done, verify_done; addr=0; go FILL.
  - FILL: issue writes back-to-back at addr 0..2**AW-1. On acceptance at the last address: set fill_done, addr=0, go VREQ.
  - VREQ: issue read at addr; on acceptance go VWAIT.
  - VWAIT: on mem_valid, compare mem_rdata with the expected pattern. On mismatch, err_cnt+1, saturating at 16'hFFFF.
    - If not the last address: addr+1, go VREQ.
    - If last address: set verify_done, addr=0, load pace counter with rate, go PWAIT.
  - PWAIT: decrement pace counter; at 0 go PREQ. rate=0 means no idle cycles.
  - PREQ: issue read; on acceptance go PRD.
  - PRD: on mem_valid, sample<=mem_rdata and sample_valid=1 for exactly that following cycle. addr+1 wraps modulo 2**AW. Reload pace counter, go PWAIT.
- stop: checked only in FILL, VREQ and PREQ when no request is pending (mem_en=0), and in PWAIT. Go IDLE; sticky flags and err_cnt are kept.
- start outside IDLE is ignored.
- mem_valid outside VWAIT/PRD is ignored.
- rst mid-operation aborts immediately: mem_en=0 the next cycle; no partial-state retention.
- Throughput: with mem_busy=0, the fill issues one write per cycle. Total fill time is 2**AW + 1 cycles from start.

Test Plan:
- AW=4, DW=8, mode 0, mem_busy=0, ideal SRAM model with valid 1 cycle after read -> writes addr 0..15 with data 0..15 on consecutive cycles; fill_done at cycle 17 after start; err_cnt=0; verify_done set.
- Same, with the model corrupting addr 5 (XOR 8'h01) and addr 9 -> err_cnt=2, verify_done=1, playback still runs.
- mode 2 (LFSR): the model stores writes; verify -> err_cnt=0. First write data = SEED low byte 8'hE1; second write data = the next LFSR value.
- rate=3 in playback -> sample_valid strobes exactly (rate + request + read-return) cycles apart. Samples cycle 0..15 then wrap to 0.
- mem_busy held high 4 cycles on the 3rd fill write -> mem_addr=2 and mem_wdata=2 stable throughout; no address skipped or duplicated.
- rst asserted mid-fill at addr 7 -> next cycle mem_en=0, active=0, fill_done=0. start then restarts from addr 0. start pulsed during PLAY -> ignored.

Source files
------------

// File: rtl/sram_pattern_engine.sv
// SRAM pattern engine: fills memory with a ramp/constant/LFSR pattern, verifies it,
// then streams wrap-around read samples at a programmable pace.
module sram_pattern_engine #(
   parameter int          AW    = 19,
   parameter int          DW    = 8,
   parameter int          DIV_W = 8,
   parameter logic [15:0] SEED  = 16'hACE1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic [1:0]       mode,
   input  logic [DIV_W-1:0] rate,
   output logic             active,
   output logic             fill_done,
   output logic             verify_done,
   output logic [15:0]      err_cnt,
   output logic [DW-1:0]    sample,
   output logic             sample_valid,
   output logic             mem_en,
   output logic             mem_we,
   output logic [AW-1:0]    mem_addr,
   output logic [DW-1:0]    mem_wdata,
   input  logic             mem_busy,
   input  logic [DW-1:0]    mem_rdata,
   input  logic             mem_valid
);

   typedef enum logic [2:0] {
      S_IDLE, S_FILL, S_VREQ, S_VWAIT, S_PWAIT, S_PREQ, S_PRD
   } state_t;

   localparam logic [AW-1:0]    ADDR_ONE = AW'(1);
   localparam logic [DIV_W-1:0] PACE_ONE = DIV_W'(1);

   state_t             state_reg, state_next;
   logic [AW-1:0]      addr_reg, addr_next;
   logic [15:0]        lfsr_reg, lfsr_next;
   logic [1:0]         mode_reg, mode_next;
   logic [DIV_W-1:0]   pace_reg, pace_next;
   logic [15:0]        err_reg, err_next;
   logic               fill_done_reg, fill_done_next;
   logic               verify_done_reg, verify_done_next;
   logic [DW-1:0]      sample_reg, sample_next;
   logic               sample_valid_reg, sample_valid_next;
   logic               hold_reg, hold_next;

   logic [DW-1:0]      ramp_word;
   logic [DW-1:0]      pattern_word;
   logic [15:0]        lfsr_step;
   logic               last_addr;
   logic               req_state;
   logic               stop_ok;
   logic               accept;

   generate
      if (AW >= DW) begin : g_ramp_hi
         assign ramp_word = addr_reg[AW-1 -: DW];
      end else begin : g_ramp_lo
         assign ramp_word = {{(DW-AW){1'b0}}, addr_reg};
      end
   endgenerate

   // Fibonacci taps 16,14,13,11 in right-shift form
   assign lfsr_step = {lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5], lfsr_reg[15:1]};
   assign last_addr = &addr_reg;

   always_comb begin
      case (mode_reg)
         2'd1:    pattern_word = SEED[DW-1:0];
         2'd2:    pattern_word = lfsr_reg[DW-1:0];
         default: pattern_word = ramp_word;
      endcase
   end

   // A request stalled by mem_busy must stay up, so stop only wins when nothing is held
   always_comb begin
      req_state = (state_reg == S_FILL) || (state_reg == S_VREQ) || (state_reg == S_PREQ);
      stop_ok   = stop && !hold_reg;
      mem_en    = req_state && !stop_ok;
      accept    = mem_en && !mem_busy;
      hold_next = mem_en && mem_busy;
   end

   always_comb begin
      state_next        = state_reg;
      addr_next         = addr_reg;
      lfsr_next         = lfsr_reg;
      mode_next         = mode_reg;
      pace_next         = pace_reg;
      err_next          = err_reg;
      fill_done_next    = fill_done_reg;
      verify_done_next  = verify_done_reg;
      sample_next       = sample_reg;
      sample_valid_next = 1'b0;

      case (state_reg)
         S_IDLE: begin
            if (start) begin
               mode_next        = mode;
               err_next         = 16'd0;
               fill_done_next   = 1'b0;
               verify_done_next = 1'b0;
               addr_next        = '0;
               lfsr_next        = SEED;
               state_next       = S_FILL;
            end
         end
         S_FILL: begin
            if (stop_ok) begin
               state_next = S_IDLE;
            end else if (accept) begin
               lfsr_next = lfsr_step;
               if (last_addr) begin
                  fill_done_next = 1'b1;
                  addr_next      = '0;
                  lfsr_next      = SEED;
                  state_next     = S_VREQ;
               end else begin
                  addr_next = addr_reg + ADDR_ONE;
               end
            end
         end
         S_VREQ: begin
            if (stop_ok) begin
               state_next = S_IDLE;
            end else if (accept) begin
               state_next = S_VWAIT;
            end
         end
         S_VWAIT: begin
            if (mem_valid) begin
               if ((mem_rdata != pattern_word) && (err_reg != 16'hFFFF)) begin
                  err_next = err_reg + 16'd1;
               end
               lfsr_next = lfsr_step;
               if (last_addr) begin
                  verify_done_next = 1'b1;
                  addr_next        = '0;
                  pace_next        = rate;
                  state_next       = (rate == '0) ? S_PREQ : S_PWAIT;
               end else begin
                  addr_next  = addr_reg + ADDR_ONE;
                  state_next = S_VREQ;
               end
            end
         end
         S_PWAIT: begin
            if (stop) begin
               state_next = S_IDLE;
            end else if (pace_reg <= PACE_ONE) begin
               pace_next  = '0;
               state_next = S_PREQ;
            end else begin
               pace_next = pace_reg - PACE_ONE;
            end
         end
         S_PREQ: begin
            if (stop_ok) begin
               state_next = S_IDLE;
            end else if (accept) begin
               state_next = S_PRD;
            end
         end
         S_PRD: begin
            if (mem_valid) begin
               sample_next       = mem_rdata;
               sample_valid_next = 1'b1;
               addr_next         = addr_reg + ADDR_ONE;
               pace_next         = rate;
               state_next        = (rate == '0) ? S_PREQ : S_PWAIT;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= S_IDLE;
         addr_reg         <= '0;
         lfsr_reg         <= SEED;
         mode_reg         <= 2'd0;
         pace_reg         <= '0;
         err_reg          <= 16'd0;
         fill_done_reg    <= 1'b0;
         verify_done_reg  <= 1'b0;
         sample_reg       <= '0;
         sample_valid_reg <= 1'b0;
         hold_reg         <= 1'b0;
      end else begin
         state_reg        <= state_next;
         addr_reg         <= addr_next;
         lfsr_reg         <= lfsr_next;
         mode_reg         <= mode_next;
         pace_reg         <= pace_next;
         err_reg          <= err_next;
         fill_done_reg    <= fill_done_next;
         verify_done_reg  <= verify_done_next;
         sample_reg       <= sample_next;
         sample_valid_reg <= sample_valid_next;
         hold_reg         <= hold_next;
      end
   end

   assign active       = (state_reg != S_IDLE);
   assign fill_done    = fill_done_reg;
   assign verify_done  = verify_done_reg;
   assign err_cnt      = err_reg;
   assign sample       = sample_reg;
   assign sample_valid = sample_valid_reg;
   assign mem_we       = (state_reg == S_FILL);
   assign mem_addr     = addr_reg;
   assign mem_wdata    = (state_reg == S_FILL) ? pattern_word : '0;

endmodule

// File: tb/tb_sram_pattern_engine.sv
// Scoreboard bench for sram_pattern_engine: ideal 1-cycle SRAM model, expected writes and
// playback samples queued at start, checked by an independent monitor.
module tb_sram_pattern_engine;
   localparam int          AW    = 4;
   localparam int          DW    = 8;
   localparam int          DIV_W = 8;
   localparam int          DEPTH = 16;
   localparam logic [15:0] SEED  = 16'hACE1;

   logic             clk = 1'b0;
   logic             rst, start, stop;
   logic [1:0]       mode;
   logic [DIV_W-1:0] rate;
   logic             active, fill_done, verify_done;
   logic [15:0]      err_cnt;
   logic [DW-1:0]    sample;
   logic             sample_valid;
   logic             mem_en, mem_we;
   logic [AW-1:0]    mem_addr;
   logic [DW-1:0]    mem_wdata;
   logic             mem_busy;
   logic [DW-1:0]    mem_rdata = '0;
   logic             mem_valid = 1'b0;

   sram_pattern_engine #(.AW(AW), .DW(DW), .DIV_W(DIV_W), .SEED(SEED)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .rate(rate),
      .active(active), .fill_done(fill_done), .verify_done(verify_done), .err_cnt(err_cnt),
      .sample(sample), .sample_valid(sample_valid),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_busy(mem_busy), .mem_rdata(mem_rdata), .mem_valid(mem_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   wr_t           wq[$];
   logic [DW-1:0] sq[$];
   logic [DW-1:0] mem_arr[DEPTH];
   logic [DW-1:0] cmask[DEPTH];
   logic [DW-1:0] first_w[2];
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            last_sv = -1;
   int            exp_period = -1;
   int            wr_idx = 0;
   bit            draining = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Reference pattern from the rules: word index a of the fill sequence
   function automatic logic [DW-1:0] ref_word(input logic [1:0] md, input int a);
      logic [15:0] l = SEED;
      case (md)
         2'd1: return l[DW-1:0];
         2'd2: begin
            for (int i = 0; i < a; i++) l = {^(l & 16'h002D), l[15:1]};
            return l[DW-1:0];
         end
         default: return DW'(a);
      endcase
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Ideal SRAM: read data returned the cycle after acceptance, optional read corruption
   always @(posedge clk) begin
      mem_valid <= 1'b0;
      if (mem_en && !mem_busy) begin
         if (mem_we) mem_arr[mem_addr] <= mem_wdata;
         else begin
            mem_rdata <= mem_arr[mem_addr] ^ cmask[mem_addr];
            mem_valid <= 1'b1;
         end
      end
   end

   always begin : monitor
      wr_t           ew;
      logic [DW-1:0] es;
      @(negedge clk);
      #1;
      if (!rst && mem_en && mem_we && !mem_busy) begin
         if (wr_idx < 2) first_w[wr_idx] = mem_wdata;
         wr_idx++;
         if (wq.size() == 0) fail_now("unexpected_write");
         else begin
            ew = wq.pop_front();
            check("wr_addr", 32'(mem_addr), 32'(ew.addr));
            check("wr_data", 32'(mem_wdata), 32'(ew.data));
         end
      end
      if (sample_valid) begin
         if (sq.size() > 0) begin
            es = sq.pop_front();
            check("sample", 32'(sample), 32'(es));
            if (exp_period > 0 && last_sv >= 0) check("sample_period", cyc - last_sv, exp_period);
            last_sv = cyc;
         end else if (!draining) begin
            fail_now("unexpected_sample");
         end
      end
   end

   task automatic run_test(input logic [1:0] md, input logic [DIV_W-1:0] rt,
                           input bit busy_stall, input bit rand_busy, input int nsamp, input bit poke);
      logic [DW-1:0] stored[DEPTH];
      int exp_err = 0;
      int n;
      bit stalled = 0;
      bit poked = 0;
      for (int a = 0; a < DEPTH; a++) begin
         stored[a] = ref_word(md, a);
         wq.push_back('{AW'(a), stored[a]});
         if (cmask[a] != '0) exp_err++;
      end
      for (int k = 0; k < nsamp; k++) sq.push_back(stored[k % DEPTH] ^ cmask[k % DEPTH]);
      mode = md;
      rate = rt;
      wr_idx = 0;
      last_sv = -1;
      draining = 0;
      exp_period = rand_busy ? -1 : int'(rt) + 2;
      $display("test mode=%0d rate=%0d stall=%0d rand_busy=%0d exp_err=%0d", md, rt, busy_stall, rand_busy, exp_err);

      mem_busy = 0;
      start = 1;
      @(negedge clk);
      start = 0;
      n = 1;
      while (n < 200) begin
         if (busy_stall && !stalled && mem_en && mem_we && mem_addr == AW'(2)) begin
            stalled = 1;
            mem_busy = 1;
            for (int s = 0; s < 4; s++) begin
               #1;
               check("stall_addr", 32'(mem_addr), 32'd2);
               check("stall_wdata", 32'(mem_wdata), 32'd2);
               check("stall_en", 32'(mem_en), 32'd1);
               @(negedge clk);
               n++;
            end
            mem_busy = 0;
         end
         #1;
         if (fill_done) break;
         @(negedge clk);
         n++;
      end
      check("fill_cycles", n, busy_stall ? 21 : 17);
      check("writes_all_seen", wq.size(), 0);
      if (md == 2'd2) begin
         check("lfsr_first", 32'(first_w[0]), 32'h0E1);
         check("lfsr_second", 32'(first_w[1]), 32'h070);
      end

      n = 0;
      while (!verify_done && n < 2000) begin
         @(negedge clk);
         if (rand_busy) mem_busy = ($urandom_range(0, 3) == 0);
         n++;
         #1;
      end
      if (n >= 2000) fail_now("verify_timeout");
      check("verify_done", 32'(verify_done), 32'd1);
      check("err_cnt", 32'(err_cnt), 32'(exp_err));

      n = 0;
      while (sq.size() > 0 && n < 5000) begin
         @(negedge clk);
         if (rand_busy) mem_busy = ($urandom_range(0, 3) == 0);
         if (poke && !poked && sq.size() < nsamp - 2) begin
            start = 1;
            poked = 1;
         end else begin
            start = 0;
         end
         n++;
      end
      start = 0;
      if (n >= 5000) fail_now("playback_timeout");
      if (poke) begin
         #1;
         check("start_ignored_active", 32'(active), 32'd1);
         check("start_ignored_fill_done", 32'(fill_done), 32'd1);
         check("start_ignored_verify_done", 32'(verify_done), 32'd1);
      end

      @(negedge clk);
      draining = 1;
      mem_busy = 0;
      stop = 1;
      n = 0;
      while (active && n < 50) begin
         @(negedge clk);
         n++;
         #1;
      end
      stop = 0;
      check("stop_active", 32'(active), 32'd0);
      check("stop_err_kept", 32'(err_cnt), 32'(exp_err));
      check("stop_verify_kept", 32'(verify_done), 32'd1);
      sq.delete();
      @(negedge clk);
   endtask

   initial begin
      int n;
      rst = 1; start = 0; stop = 0; mode = 2'd0; rate = '0; mem_busy = 0;
      for (int a = 0; a < DEPTH; a++) begin
         cmask[a] = '0;
         mem_arr[a] = '0;
      end
      repeat (3) @(negedge clk);
      rst = 0;
      #1;
      check("rst_active", 32'(active), 32'd0);
      check("rst_mem_en", 32'(mem_en), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      check("rst_fill_done", 32'(fill_done), 32'd0);
      check("rst_verify_done", 32'(verify_done), 32'd0);
      check("rst_err_cnt", 32'(err_cnt), 32'd0);
      check("rst_sample_valid", 32'(sample_valid), 32'd0);
      check("rst_sample", 32'(sample), 32'd0);

      run_test(2'd0, 8'd3, 0, 0, 18, 1);

      cmask[5] = 8'h01;
      cmask[9] = 8'h01;
      run_test(2'd0, DIV_W'($urandom_range(0, 4)), 0, 0, 20, 0);
      cmask[5] = '0;
      cmask[9] = '0;

      run_test(2'd2, DIV_W'($urandom_range(0, 4)), 0, 0, 16, 0);
      run_test(2'd3, DIV_W'($urandom_range(0, 4)), 1, 1, 17, 0);

      // Reset in the middle of a fill, then a clean restart
      for (int a = 0; a < DEPTH; a++) wq.push_back('{AW'(a), ref_word(2'd1, a)});
      mode = 2'd1;
      draining = 0;
      start = 1;
      @(negedge clk);
      start = 0;
      n = 0;
      while (!(mem_en && mem_we && mem_addr == AW'(7)) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) fail_now("reach_addr7_timeout");
      rst = 1;
      @(negedge clk);
      rst = 0;
      #1;
      check("midrst_mem_en", 32'(mem_en), 32'd0);
      check("midrst_active", 32'(active), 32'd0);
      check("midrst_fill_done", 32'(fill_done), 32'd0);
      check("midrst_mem_addr", 32'(mem_addr), 32'd0);
      wq.delete();
      @(negedge clk);
      run_test(2'd1, DIV_W'($urandom_range(0, 4)), 0, 0, 16, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout (cycle %0d)", cyc);
      $fatal(1, "timeout");
   end
endmodule
